// File: rtl/uart_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter: FSM states and
// frame constants.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        START,
        DATA,
        STOP
    } uart_tx_state_t;

    localparam int   UART_DATA_BITS = 8;
    localparam logic UART_START_LVL = 1'b0;
    localparam logic UART_STOP_LVL  = 1'b1;

endpackage

// File: rtl/uart_baud_counter.sv
// Counts CLK cycles within one UART bit; bit_end pulses on the last cycle of
// each bit and the counter wraps to zero there.
module uart_baud_counter #(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic CLK,
    input  logic RST,
    input  logic clear,
    input  logic en,
    output logic bit_end
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // clear only steers the next count; bit_end stays a function of the
    // current count so the FSM can use it to decide its own transition.
    always_comb begin
        // NOTE: every variable gets a default first, so no path infers a latch.
        cnt_d   = cnt_q;
        bit_end = en && (cnt_q == LAST_CNT);
        if (clear) begin
            cnt_d = '0;
        end else if (bit_end) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples its inputs from before the clock edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// 8N1 UART transmitter that pops bytes from a registered-read FIFO and
// shifts them out LSB first on a registered tx line.
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       enable,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_read,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);

    localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

    uart_tx_state_t state_q;
    uart_tx_state_t state_d;

    logic [UART_DATA_BITS-1:0] shreg_q;
    logic [UART_DATA_BITS-1:0] shreg_d;
    logic [2:0]                bit_cnt_q;
    logic [2:0]                bit_cnt_d;
    logic                      tx_q;
    logic                      tx_d;

    logic bit_end;
    logic baud_clear;
    logic baud_en;

    uart_baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .CLK    (CLK),
        .RST    (RST),
        .clear  (baud_clear),
        .en     (baud_en),
        .bit_end(bit_end)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // enable and fifo_empty matter only at the IDLE decision; a running frame
    // always completes.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable && !fifo_empty) state_d = FETCH;
            FETCH:   state_d = LOAD;
            LOAD:    state_d = START;
            START:   if (bit_end) state_d = DATA;
            DATA:    if (bit_end && (bit_cnt_q == LAST_BIT)) state_d = STOP;
            STOP:    if (bit_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Any state change restarts the baud count, covering entry to every bit.
    always_comb begin
        fifo_read  = (state_q == FETCH);
        busy       = (state_q != IDLE);
        tx_done    = (state_q == STOP) && bit_end;
        baud_en    = (state_q == START) || (state_q == DATA) || (state_q == STOP);
        baud_clear = (state_d != state_q);
        tx         = tx_q;
    end

    // The FIFO's registered read makes fifo_data valid during LOAD, so the
    // byte is captured on the LOAD->START edge.
    always_comb begin
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        case (state_q)
            LOAD:  shreg_d = fifo_data;
            START: bit_cnt_d = '0;
            DATA: begin
                if (bit_end) begin
                    shreg_d   = shreg_q >> 1;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end
            end
            default: ;
        endcase
    end

    // tx is registered from the next state so it changes exactly at bit edges.
    always_comb begin
        case (state_d)
            START:   tx_d = UART_START_LVL;
            DATA:    tx_d = shreg_d[0];
            default: tx_d = UART_STOP_LVL;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            tx_q      <= UART_STOP_LVL;
        end else begin
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with CLKS_PER_BIT=4, fed by a small
// registered-read FIFO model; frames are checked cycle by cycle on tx.
module tb_fifo_uart_tx;

    localparam int CPB = 4;

    logic       CLK;
    logic       RST;
    logic       enable;
    logic       fifo_empty;
    logic [7:0] fifo_data = 8'h00;
    logic       fifo_read;
    logic       tx;
    logic       busy;
    logic       tx_done;

    int n_checks = 0;
    int n_err    = 0;

    fifo_uart_tx #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .enable    (enable),
        .fifo_empty(fifo_empty),
        .fifo_data (fifo_data),
        .fifo_read (fifo_read),
        .tx        (tx),
        .busy      (busy),
        .tx_done   (tx_done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // FIFO model: pushes from the stimulus at negedges, pops on read strobes.
    logic [7:0] mem [16];
    int         wp = 0;
    int         rp = 0;
    int         rd_cnt = 0;
    int         rd_empty_err = 0;

    assign fifo_empty = (wp == rp);

    always @(posedge CLK) begin
        if (fifo_read) begin
            if (wp == rp) rd_empty_err <= rd_empty_err + 1;
            else begin
                fifo_data <= mem[rp[3:0]];
                rp        <= rp + 1;
            end
        end
    end

    always @(negedge CLK) begin
        if (fifo_read) rd_cnt <= rd_cnt + 1;
    end

    task automatic push(input logic [7:0] b);
        mem[wp[3:0]] = b;
        wp = wp + 1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Waits for the start bit, then samples every cycle of the 10-bit frame.
    // exp[i] is the line level during bit time i (bit 0 = start bit).
    // gap = number of tx-high cycles seen before the start bit.
    // Returns on the last stop-bit cycle.
    task automatic check_frame(input string name, input logic [9:0] exp, output int gap);
        logic       found;
        logic [9:0] got;
        logic       stable;
        logic       busy_ok;
        int         done_cnt;
        logic       done_last;
        gap       = 0;
        found     = 1'b0;
        got       = '0;
        stable    = 1'b1;
        busy_ok   = 1'b1;
        done_cnt  = 0;
        done_last = 1'b0;
        for (int w = 0; w < 200 && !found; w++) begin
            @(negedge CLK);
            if (tx === 1'b0) found = 1'b1;
            else gap++;
        end
        check({name, " start_seen"}, 32'(found), 32'd1);
        if (!found) return;
        for (int i = 0; i < 10; i++) begin
            for (int c = 0; c < CPB; c++) begin
                if (!(i == 0 && c == 0)) @(negedge CLK);
                if (c == 0) got[i] = tx;
                else if (tx !== got[i]) stable = 1'b0;
                if (busy !== 1'b1) busy_ok = 1'b0;
                if (tx_done === 1'b1) done_cnt++;
                if (i == 9 && c == CPB - 1) done_last = tx_done;
            end
        end
        check({name, " bits"}, 32'(got), 32'(exp));
        check({name, " bit_stable"}, 32'(stable), 32'd1);
        check({name, " busy_in_frame"}, 32'(busy_ok), 32'd1);
        check({name, " tx_done_count"}, 32'(done_cnt), 32'd1);
        check({name, " tx_done_last"}, 32'(done_last), 32'd1);
    endtask

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int         g;
        int         base;
        logic       line_ok;
        logic       idle_ok;
        logic [9:0] exp_f;

        vecs[0] = '{data: 8'hA5, frame: 10'b1101001010};
        vecs[1] = '{data: 8'h00, frame: 10'b1000000000};
        vecs[2] = '{data: 8'hFF, frame: 10'b1111111110};
        vecs[3] = '{data: 8'h3C, frame: 10'b1001111000};
        vecs[4] = '{data: 8'h42, frame: 10'b1010000100};

        RST    = 1'b1;
        enable = 1'b0;
        repeat (3) @(negedge CLK);
        check("reset tx", 32'(tx), 32'd1);
        check("reset busy", 32'(busy), 32'd0);
        check("reset fifo_read", 32'(fifo_read), 32'd0);
        check("reset tx_done", 32'(tx_done), 32'd0);
        RST    = 1'b0;
        enable = 1'b1;

        // Enabled with an empty FIFO: nothing may happen.
        line_ok = 1'b1;
        idle_ok = 1'b1;
        repeat (100) begin
            @(negedge CLK);
            if (tx !== 1'b1) line_ok = 1'b0;
            if (busy !== 1'b0) idle_ok = 1'b0;
        end
        check("empty tx_high", 32'(line_ok), 32'd1);
        check("empty not_busy", 32'(idle_ok), 32'd1);
        check("empty no_read", 32'(rd_cnt), 32'd0);

        // Single frames; push at a negedge, start bit on the 3rd rising edge.
        foreach (vecs[i]) begin
            base = rd_cnt;
            push(vecs[i].data);
            check_frame($sformatf("vec%0d", i), vecs[i].frame, g);
            check($sformatf("vec%0d latency", i), 32'(g), 32'd2);
            @(negedge CLK);
            check($sformatf("vec%0d busy_after", i), 32'(busy), 32'd0);
            check($sformatf("vec%0d one_read", i), 32'(rd_cnt - base), 32'd1);
            check($sformatf("vec%0d fifo_empty", i), 32'(fifo_empty), 32'd1);
            repeat (5) @(negedge CLK);
        end

        // Back-to-back frames separated by IDLE, FETCH, LOAD.
        base = rd_cnt;
        push(8'h00);
        push(8'hFF);
        push(8'h3C);
        check_frame("b2b 00", 10'b1000000000, g);
        check("b2b first latency", 32'(g), 32'd2);
        check_frame("b2b FF", 10'b1111111110, g);
        check("b2b gap1", 32'(g), 32'd3);
        check_frame("b2b 3C", 10'b1001111000, g);
        check("b2b gap2", 32'(g), 32'd3);
        repeat (10) @(negedge CLK);
        check("b2b reads", 32'(rd_cnt - base), 32'd3);

        // Full FIFO drained in order, no read past the 16th byte.
        enable = 1'b0;
        base   = rd_cnt;
        for (int k = 0; k < 16; k++) push(8'(k));
        repeat (10) @(negedge CLK);
        check("full held_off", 32'(rd_cnt - base), 32'd0);
        check("full not_empty", 32'(fifo_empty), 32'd0);
        enable = 1'b1;
        for (int k = 0; k < 16; k++) begin
            exp_f = {1'b1, 8'(k), 1'b0};
            check_frame($sformatf("full%0d", k), exp_f, g);
            check($sformatf("full%0d gap", k), 32'(g), (k == 0) ? 32'd2 : 32'd3);
            check($sformatf("full%0d empty_flag", k), 32'(fifo_empty), 32'(k == 15));
        end
        repeat (20) @(negedge CLK);
        check("full reads", 32'(rd_cnt - base), 32'd16);
        check("full idle", 32'(busy), 32'd0);

        // enable dropped during DATA bit 3 of 0x55: frame completes, 0x66 waits.
        base = rd_cnt;
        push(8'h55);
        push(8'h66);
        fork
            check_frame("en 55", 10'b1010101010, g);
            begin
                repeat (20) @(negedge CLK);
                enable = 1'b0;
            end
        join
        check("en 55 latency", 32'(g), 32'd2);
        repeat (30) @(negedge CLK);
        check("en held reads", 32'(rd_cnt - base), 32'd1);
        check("en held idle", 32'(busy), 32'd0);
        check("en held tx", 32'(tx), 32'd1);
        check("en held queued", 32'(fifo_empty), 32'd0);
        enable = 1'b1;
        check_frame("en 66", 10'b1011001100, g);
        check("en 66 latency", 32'(g), 32'd2);
        check("en reads", 32'(rd_cnt - base), 32'd2);

        // Reset in DATA bit 2 of 0x81: that byte is lost, 0x42 follows.
        repeat (5) @(negedge CLK);
        base = rd_cnt;
        push(8'h81);
        push(8'h42);
        repeat (17) @(negedge CLK);
        check("rst mid busy_before", 32'(busy), 32'd1);
        RST = 1'b1;
        #1;
        check("rst mid tx", 32'(tx), 32'd1);
        check("rst mid busy", 32'(busy), 32'd0);
        check("rst mid fifo_read", 32'(fifo_read), 32'd0);
        check("rst mid tx_done", 32'(tx_done), 32'd0);
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        check_frame("rst 42", vecs[4].frame, g);
        check("rst 42 latency", 32'(g), 32'd2);
        repeat (10) @(negedge CLK);
        check("rst reads", 32'(rd_cnt - base), 32'd2);
        check("rst fifo_empty", 32'(fifo_empty), 32'd1);
        check("no read while empty", 32'(rd_empty_err), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Byte-serial UART transmitter that drains the 16-deep, 8-bit `fifo` from its read side. When enabled and the FIFO is non-empty, it pops one byte using the FIFO's one-cycle registered-read protocol. It then shifts the byte out as an 8N1 frame on `tx`: 1 start bit, 8 data bits LSB first, 1 stop bit, no parity. It sits between the FIFO and the board's UART TX pin.

## Interface
- `CLKS_PER_BIT`, default 104: `CLK` cycles per UART bit (12 MHz / 115200 baud). Legal range is ≥ 2.
- `CLK` in 1: system clock; all state changes on its rising edge.
- `RST` in 1: reset, asynchronous and active-high.
- `enable` in 1: permits starting new frames; sampled only in IDLE.
- `fifo_empty` in 1: FIFO `empty` flag.
- `fifo_data` in 8: FIFO `oData`. Valid in the cycle after `fifo_read` was high.
- `fifo_read` out 1: FIFO `read` strobe; a one-cycle pulse per byte.
- `tx` out 1: serial line; idles high.
- `busy` out 1: high whenever state ≠ IDLE.
- `tx_done` out 1: one-cycle pulse on the last cycle of the stop bit.

## Operation
- States:
  - IDLE → FETCH when `enable && !fifo_empty`.
  - FETCH → LOAD, unconditionally.
  - LOAD → START; `fifo_data` is captured into an 8-bit shift register on this edge.
  - START → DATA after `CLKS_PER_BIT` cycles.
  - DATA → STOP after 8 bits.
  - STOP → IDLE after `CLKS_PER_BIT` cycles.
- `fifo_read` is high only in FETCH: exactly one cycle, one pop per frame. It is never asserted while `fifo_empty` was high at the IDLE decision.
- `tx` is a registered output:
  - 0 throughout START;
  - `shreg[0]` throughout each DATA bit, with a right shift at the end of each bit;
  - 1 in STOP, IDLE, FETCH and LOAD.
- Baud counter:
  - width `$clog2(CLKS_PER_BIT)`;
  - cleared on entry to START, DATA and STOP;
  - a bit ends when the counter reaches `CLKS_PER_BIT-1`, with wrap to 0.
- Bit counter: 3 bits, counts 0..7 in DATA; DATA exits when it equals 7 at bit end.
- `enable` deasserted mid-frame: the current frame completes normally; no new FETCH is issued.
- `fifo_empty` is ignored outside IDLE. Writes to the FIFO during a frame do not disturb it.
- Back-to-back bytes: after STOP, IDLE re-evaluates the conditions and the next frame follows.
- Reset, including mid-frame: state = IDLE, `tx`=1, `fifo_read`=0, `busy`=0, `tx_done`=0, counters and shift register = 0. A byte already popped is discarded.

## Timing
- Reset values: `tx`=1, `fifo_read`=0, `busy`=0, `tx_done`=0.
- Example with `enable`=1 and `fifo_empty` low at cycle 0's edge:
  - cycle 1: FETCH, `fifo_read`=1;
  - cycle 2: LOAD, `fifo_data` valid;
  - cycle 3: first cycle of `tx`=0.
- Frame length: `10*CLKS_PER_BIT` cycles from start-bit begin to stop-bit end.
- `tx_done` is high on the final stop-bit cycle; `busy` drops on the next cycle.
- Inter-frame idle-high gap: exactly 3 cycles (IDLE, FETCH, LOAD) when data is continuously available.
- Latency from empty→non-empty (seen in IDLE) to start bit: 3 cycles.

## Structure
- Shared package `uart_pkg`:
  - state enum `uart_tx_state_t` (IDLE, FETCH, LOAD, START, DATA, STOP);
  - `UART_DATA_BITS`=8;
  - `UART_START_LVL`=0, `UART_STOP_LVL`=1.
- One natural sub-module, `uart_baud_counter`: parameter `CLKS_PER_BIT`, inputs `clear`/`en`, output `bit_end` pulse. The FSM and shift register stay in `fifo_uart_tx`.

## Test plan
- Reset release with `CLKS_PER_BIT`=4, FIFO empty → `tx`=1, `busy`=0, and `fifo_read` never pulses over 100 cycles.
- Write 0xA5, `enable`=1 → exactly one `fifo_read` pulse, then `tx` = 0,1,0,1,0,0,1,0,1,1. Each level lasts 4 cycles; `tx_done` pulses once; FIFO ends empty.
- Write 0x00, 0xFF, 0x3C back-to-back → three frames decoded in order, each separated by exactly 3 idle-high cycles; 3 `fifo_read` pulses total.
- Fill FIFO to full (16 bytes 0x00..0x0F), `enable`=1 → 16 frames decoded in order; `fifo_empty` rises after the 16th pop; no 17th read.
- Deassert `enable` during the DATA bit 3 of 0x55 → the frame completes intact; the next queued byte 0x66 is not popped until `enable` returns.
- Assert `RST` mid-DATA of 0x81 → `tx`=1 and `busy`=0 immediately. After release with a non-empty FIFO, the next frame carries the following queued byte, not 0x81.
